// File: rtl/incoming_response_buffer_v2.sv
// R-beat ingress FIFO: arrival-order storage at any depth >= 2, with occupancy, burst count,
// almost-full flag and synchronous flush. Define IRB_ERR_CNT_EN to enable the error-beat counter.
module incoming_response_buffer_v2 #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RESP_WIDTH = 2,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  // R beats from the AXI slave
  input  logic [ID_WIDTH-1:0]   r_in_id,
  input  logic [DATA_WIDTH-1:0] r_in_data,
  input  logic [RESP_WIDTH-1:0] r_in_resp,
  input  logic                  r_in_last,
  input  logic                  r_in_valid,
  output logic                  r_in_ready,
  // R beats toward r_ordering_unit
  output logic [ID_WIDTH-1:0]   r_out_id,
  output logic [DATA_WIDTH-1:0] r_out_data,
  output logic [RESP_WIDTH-1:0] r_out_resp,
  output logic                  r_out_last,
  output logic                  r_out_valid,
  input  logic                  r_out_ready,
  input  logic                  flush,
  output logic [CNT_W-1:0]      count,
  output logic [CNT_W-1:0]      burst_cnt,
  output logic                  almost_full,
  output logic [15:0]           err_cnt
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned ENTRY_W = ID_WIDTH + DATA_WIDTH + RESP_WIDTH + 1;

  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AfCnt    = CNT_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] PtrLast  = PTR_W'(DEPTH - 1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             af_q, af_d;

  logic full, empty, push, pop, push_last, pop_last;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);

  // Ready ignores a same-cycle pop: no write-through when full.
  assign r_in_ready  = ~full & ~flush;
  assign r_out_valid = ~empty & ~flush;

  assign push = r_in_valid & r_in_ready;
  assign pop  = r_out_valid & r_out_ready;

  assign {r_out_id, r_out_data, r_out_resp, r_out_last} = mem_q[rd_ptr_q];

  assign push_last = push & r_in_last;
  assign pop_last  = pop & r_out_last;

  // Storage is deliberately not reset; valid gates its visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {r_in_id, r_in_data, r_in_resp, r_in_last};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    burst_d  = burst_q;

    // Explicit wrap keeps non-power-of-2 depths correct.
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case ({push_last, pop_last})
      2'b10:   burst_d = burst_q + CNT_W'(1);
      2'b01:   burst_d = burst_q - CNT_W'(1);
      default: burst_d = burst_q;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      burst_d  = '0;
    end

    // Registered from next-state count so it lines up with count.
    af_d = (count_d >= AfCnt);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      burst_q  <= '0;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      burst_q  <= burst_d;
      af_q     <= af_d;
    end
  end

  assign count       = count_q;
  assign burst_cnt   = burst_q;
  assign almost_full = af_q;

`ifdef IRB_ERR_CNT_EN
  logic [15:0] err_q;

  // Counts SLVERR/DECERR beats; saturates, survives flush, clears only on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= '0;
    end else if (push & r_in_resp[1] & ~(&err_q)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_incoming_response_buffer_v2.sv
// Bench for incoming_response_buffer_v2 at a non-power-of-2 depth, checked against a queue model.
module tb_incoming_response_buffer_v2;

  localparam int unsigned DEPTH = 5;
  localparam int unsigned AF    = DEPTH - 2;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       r_in_id;
  logic [63:0]      r_in_data;
  logic [1:0]       r_in_resp;
  logic             r_in_last;
  logic             r_in_valid;
  logic             r_in_ready;
  logic [3:0]       r_out_id;
  logic [63:0]      r_out_data;
  logic [1:0]       r_out_resp;
  logic             r_out_last;
  logic             r_out_valid;
  logic             r_out_ready;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] burst_cnt;
  logic             almost_full;
  logic [15:0]      err_cnt;

  always #5 clk = ~clk;

  incoming_response_buffer_v2 #(
    .ID_WIDTH  (4),
    .DATA_WIDTH(64),
    .RESP_WIDTH(2),
    .DEPTH     (DEPTH)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .r_in_id    (r_in_id),
    .r_in_data  (r_in_data),
    .r_in_resp  (r_in_resp),
    .r_in_last  (r_in_last),
    .r_in_valid (r_in_valid),
    .r_in_ready (r_in_ready),
    .r_out_id   (r_out_id),
    .r_out_data (r_out_data),
    .r_out_resp (r_out_resp),
    .r_out_last (r_out_last),
    .r_out_valid(r_out_valid),
    .r_out_ready(r_out_ready),
    .flush      (flush),
    .count      (count),
    .burst_cnt  (burst_cnt),
    .almost_full(almost_full),
    .err_cnt    (err_cnt)
  );

  // Reference model: contents in arrival order plus an error tally.
  beat_t       q[$];
  int unsigned err_m;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input int id, input logic [63:0] data, input logic [1:0] resp,
                               input logic last);
    beat_t b;
    b.id   = 4'(id);
    b.data = data;
    b.resp = resp;
    b.last = last;
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    return mk(int'($urandom_range(15)), {$urandom, $urandom}, 2'($urandom_range(3)),
              1'($urandom_range(1)));
  endfunction

  task automatic check_regs(input string tag);
    int unsigned lasts = 0;
    foreach (q[i]) if (q[i].last) lasts++;
    check({tag, ".count"}, 64'(count), 64'(q.size()));
    check({tag, ".burst_cnt"}, 64'(burst_cnt), 64'(lasts));
    check({tag, ".almost_full"}, 64'(almost_full), 64'(q.size() >= AF));
`ifdef IRB_ERR_CNT_EN
    check({tag, ".err_cnt"}, 64'(err_cnt), 64'(err_m));
`else
    check({tag, ".err_cnt"}, 64'(err_cnt), 64'(0));
`endif
  endtask

  // One clock of stimulus: drive at negedge, check handshake/head, update model, check state.
  task automatic step(input string tag, input logic iv, input beat_t b, input logic ordy,
                      input logic fl);
    logic rdy_e, vld_e;
    @(negedge clk);
    r_in_valid  = iv;
    r_in_id     = b.id;
    r_in_data   = b.data;
    r_in_resp   = b.resp;
    r_in_last   = b.last;
    r_out_ready = ordy;
    flush       = fl;
    #1;
    rdy_e = (q.size() < DEPTH) && !fl;
    vld_e = (q.size() != 0) && !fl;
    check({tag, ".in_ready"}, 64'(r_in_ready), 64'(rdy_e));
    check({tag, ".out_valid"}, 64'(r_out_valid), 64'(vld_e));
    if (vld_e) begin
      check({tag, ".out_id"}, 64'(r_out_id), 64'(q[0].id));
      check({tag, ".out_data"}, r_out_data, q[0].data);
      check({tag, ".out_resp"}, 64'(r_out_resp), 64'(q[0].resp));
      check({tag, ".out_last"}, 64'(r_out_last), 64'(q[0].last));
    end
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (vld_e && ordy) void'(q.pop_front());
      if (iv && rdy_e) begin
        q.push_back(b);
        if (b.resp[1] && err_m < 32'hFFFF) err_m++;
      end
    end
    #1;
    check_regs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst        = 1'b0;
    r_in_valid = 1'b1;
    flush      = 1'b0;
    @(posedge clk);
    q.delete();
    err_m = 0;
    #1;
    check_regs(tag);
    check({tag, ".out_valid"}, 64'(r_out_valid), 64'(0));
    check({tag, ".in_ready"}, 64'(r_in_ready), 64'(1));
    @(negedge clk);
    rst        = 1'b1;
    r_in_valid = 1'b0;
  endtask

  initial begin
    beat_t idle;
    idle        = mk(0, 64'h0, 2'b00, 1'b0);
    err_m       = 0;
    rst         = 1'b0;
    r_in_valid  = 1'b0;
    r_in_id     = '0;
    r_in_data   = '0;
    r_in_resp   = '0;
    r_in_last   = 1'b0;
    r_out_ready = 1'b0;
    flush       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    check("reset.out_valid", 64'(r_out_valid), 64'(0));
    check("reset.in_ready", 64'(r_in_ready), 64'(1));
    @(negedge clk);
    rst = 1'b1;

    // Fill to full with bursts ending on beats 2 and 5, then push against a full FIFO.
    for (int i = 1; i <= DEPTH; i++) begin
      step("fill", 1'b1, mk(i, 64'(i * 16'h1111), 2'b00, (i == 2) || (i == DEPTH)), 1'b0, 1'b0);
    end
    step("full_hold", 1'b1, mk(9, 64'h99, 2'b00, 1'b0), 1'b0, 1'b0);
    // Push and pop together while full: only the pop completes.
    step("full_both", 1'b1, mk(10, 64'hAA, 2'b00, 1'b0), 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step("drain", 1'b0, idle, 1'b1, 1'b0);

    // Both sides toggling 1010...; pointers wrap several times at depth 5.
    for (int i = 0; i < 40; i++) begin
      step("toggle", 1'((i + 1) % 2), mk(i % 16, 64'(i) << 8, 2'b00, 1'(i % 3 == 2)),
           1'(i % 2), 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, idle, 1'b1, 1'b0);

    // Single push into empty: visible exactly one cycle later.
    step("single", 1'b1, mk(3, 64'hDEADBEEF, 2'b01, 1'b1), 1'b0, 1'b0);
    step("single_vis", 1'b0, idle, 1'b0, 1'b0);
    step("to3_a", 1'b1, mk(4, 64'h4, 2'b00, 1'b0), 1'b0, 1'b0);
    step("to3_b", 1'b1, mk(5, 64'h5, 2'b00, 1'b1), 1'b0, 1'b0);
    step("both_at3", 1'b1, mk(6, 64'h6, 2'b00, 1'b0), 1'b1, 1'b0);

    // Flush: one-cycle, then held with traffic offered on both sides.
    step("preflush", 1'b1, mk(7, 64'h7, 2'b00, 1'b1), 1'b0, 1'b0);
    step("flush1", 1'b1, mk(8, 64'h8, 2'b10, 1'b1), 1'b1, 1'b1);
    step("post_flush", 1'b0, idle, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("reload", 1'b1, mk(i, 64'(i), 2'b11, 1'b1), 1'b0, 1'b0);
    step("flush_h1", 1'b1, mk(1, 64'h1, 2'b10, 1'b1), 1'b1, 1'b1);
    step("flush_h2", 1'b1, mk(2, 64'h2, 2'b10, 1'b1), 1'b1, 1'b1);

    // Reset in mid-stream also clears the error counter.
    for (int i = 0; i < 3; i++) step("prerst", 1'b1, mk(i, 64'(i), 2'b10, 1'(i == 1)), 1'b0, 1'b0);
    do_reset("midrst");

    // Error responses: only resp[1]=1 beats count.
    step("err_10", 1'b1, mk(1, 64'h1, 2'b10, 1'b0), 1'b0, 1'b0);
    step("err_11", 1'b1, mk(2, 64'h2, 2'b11, 1'b0), 1'b0, 1'b0);
    step("err_00", 1'b1, mk(3, 64'h3, 2'b00, 1'b0), 1'b0, 1'b0);
    step("err_01", 1'b1, mk(4, 64'h4, 2'b01, 1'b1), 1'b0, 1'b0);
`ifdef IRB_ERR_CNT_EN
    check("err_total", 64'(err_cnt), 64'(2));
`else
    check("err_total", 64'(err_cnt), 64'(0));
`endif

    // Randomised traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(1)), rnd_beat(), 1'($urandom_range(1)),
           1'($urandom_range(31) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
